// File: rtl/prim_assembler_pkg.sv
// Shared types and constants for the primitive assembler: frame markers, word-count
// helper, and mappings from flat vertex/colour buses onto Triangle3D / Color.
package prim_assembler_pkg;

   localparam int WORD_W_DEF   = 32;
   localparam int COORD_W_DEF  = 16;
   localparam int NUM_VERT_DEF = 3;
   localparam int COLOR_W_DEF  = 8;

   localparam logic [31:0] FRAME_START_DEF = 32'h0000_0000;
   localparam logic [31:0] FRAME_END_DEF   = 32'h0000_0001;

   // First-declared member sits in the MSBs, so x lands in the LSBs of each vertex.
   typedef struct packed {
      logic [COORD_W_DEF-1:0] z;
      logic [COORD_W_DEF-1:0] y;
      logic [COORD_W_DEF-1:0] x;
   } Vertex3D;

   typedef struct packed {
      Vertex3D r;
      Vertex3D q;
      Vertex3D p;
   } Triangle3D;

   typedef struct packed {
      logic [COLOR_W_DEF-1:0] b;
      logic [COLOR_W_DEF-1:0] g;
      logic [COLOR_W_DEF-1:0] r;
   } Color;

   function automatic int prim_words(input int pay_bits, input int word_w);
      return (pay_bits + word_w - 1) / word_w;
   endfunction

   function automatic Triangle3D unpack_triangle(input logic [$bits(Triangle3D)-1:0] flat);
      return Triangle3D'(flat);
   endfunction

   function automatic logic [$bits(Triangle3D)-1:0] pack_triangle(input Triangle3D tri_in);
      return tri_in;
   endfunction

   function automatic Color unpack_color(input logic [$bits(Color)-1:0] flat);
      return Color'(flat);
   endfunction

   function automatic logic [$bits(Color)-1:0] pack_color(input Color col_in);
      return col_in;
   endfunction

endpackage

// File: rtl/prim_fifo.sv
// Synchronous FIFO, write-to-read latency one cycle; push ignored when full, pop
// ignored when empty. dout reads zero while empty so a reset clears the visible head.
module prim_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (n_rst && do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/prim_assembler.sv
// Unpacks START/payload/END framed bus words into primitives queued in a FIFO;
// head valid the cycle after FRAME_END. Bus stalls (read_buffer low) only while the FIFO is full.
module prim_assembler
   import prim_assembler_pkg::*;
#(
   parameter int                WORD_W      = WORD_W_DEF,
   parameter int                COORD_W     = COORD_W_DEF,
   parameter int                NUM_VERT    = NUM_VERT_DEF,
   parameter int                COLOR_W     = COLOR_W_DEF,
   parameter int                DEPTH       = 4,
   parameter logic [WORD_W-1:0] FRAME_START = WORD_W'(FRAME_START_DEF),
   parameter logic [WORD_W-1:0] FRAME_END   = WORD_W'(FRAME_END_DEF)
) (
   input  logic                            clk,
   input  logic                            n_rst,
   input  logic [WORD_W-1:0]               ahb_buffer,
   input  logic                            ahb_data_available,
   output logic                            ahb_user_read_buffer,
   input  logic                            prim_read,
   output logic                            prim_valid,
   output logic [NUM_VERT*3*COORD_W-1:0]   prim_vertices,
   output logic [3*COLOR_W-1:0]            prim_color,
   output logic [$clog2(DEPTH+1)-1:0]      prim_count,
   output logic                            frame_error,
   output logic [7:0]                      err_count
);

   localparam int VERT_BITS  = NUM_VERT * 3 * COORD_W;
   localparam int PAY_BITS   = VERT_BITS + 3 * COLOR_W;
   localparam int PRIM_WORDS = prim_words(PAY_BITS, WORD_W);
   localparam int BUF_BITS   = PRIM_WORDS * WORD_W;
   localparam int IDX_W      = (PRIM_WORDS > 1) ? $clog2(PRIM_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PRIM_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_TAIL = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   idx_nxt;
   logic [BUF_BITS-1:0] payload;
   logic               accept;
   logic               load_en;
   logic               push;
   logic               err_set;
   logic               fifo_full;
   logic               fifo_empty;
   logic [PAY_BITS-1:0] fifo_dout;

   assign ahb_user_read_buffer = !fifo_full;
   assign accept               = ahb_data_available && ahb_user_read_buffer;
   assign prim_valid           = !fifo_empty;
   assign prim_vertices        = fifo_dout[VERT_BITS-1:0];
   assign prim_color           = fifo_dout[PAY_BITS-1:VERT_BITS];

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      load_en   = 1'b0;
      push      = 1'b0;
      err_set   = 1'b0;
      if (accept) begin
         case (state)
            ST_IDLE: begin
               if (ahb_buffer == FRAME_START) begin
                  state_nxt = ST_LOAD;
                  idx_nxt   = '0;
               end else begin
                  err_set = 1'b1;
               end
            end
            ST_LOAD: begin
               // Markers are plain data here; only the word count ends the payload.
               load_en = 1'b1;
               if (idx == LAST_IDX) begin
                  state_nxt = ST_TAIL;
                  idx_nxt   = '0;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
            ST_TAIL: begin
               if (ahb_buffer == FRAME_END) begin
                  push      = 1'b1;
                  state_nxt = ST_IDLE;
               end else if (ahb_buffer == FRAME_START) begin
                  err_set   = 1'b1;
                  state_nxt = ST_LOAD;
                  idx_nxt   = '0;
               end else begin
                  err_set   = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state       <= ST_IDLE;
         idx         <= '0;
         payload     <= '0;
         frame_error <= 1'b0;
         err_count   <= '0;
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         frame_error <= err_set;
         if (load_en) payload[int'(idx)*WORD_W +: WORD_W] <= ahb_buffer;
         if (err_set && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end

   generate
      if (BUF_BITS > PAY_BITS) begin : g_pad
         logic unused_pad;
         assign unused_pad = ^payload[BUF_BITS-1:PAY_BITS];
      end
   endgenerate

   prim_fifo #(
      .WIDTH (PAY_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (push),
      .pop   (prim_read),
      .din   (payload[PAY_BITS-1:0]),
      .dout  (fifo_dout),
      .count (prim_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_prim_assembler.sv
// Directed-vector bench for prim_assembler with a small expected-primitive queue.
module tb_prim_assembler;
   import prim_assembler_pkg::*;

   localparam logic [31:0] START = 32'h0000_0000;
   localparam logic [31:0] FEND  = 32'h0000_0001;

   logic         tb_clk;
   logic         n_rst;
   logic [31:0]  ahb_buffer;
   logic         ahb_data_available;
   logic         ahb_user_read_buffer;
   logic         prim_read;
   logic         prim_valid;
   logic [143:0] prim_vertices;
   logic [23:0]  prim_color;
   logic [2:0]   prim_count;
   logic         frame_error;
   logic [7:0]   err_count;

   int n_vec = 0;
   int n_bad = 0;
   logic [191:0] exp_q[$];
   Triangle3D    tri_v;

   prim_assembler dut (
      .clk                  (tb_clk),
      .n_rst                (n_rst),
      .ahb_buffer           (ahb_buffer),
      .ahb_data_available   (ahb_data_available),
      .ahb_user_read_buffer (ahb_user_read_buffer),
      .prim_read            (prim_read),
      .prim_valid           (prim_valid),
      .prim_vertices        (prim_vertices),
      .prim_color           (prim_color),
      .prim_count           (prim_count),
      .frame_error          (frame_error),
      .err_count            (err_count)
   );

   initial begin
      tb_clk = 1'b0;
      forever #5 tb_clk = ~tb_clk;
   end

   task automatic chk(input string tag, input logic [191:0] act, input logic [191:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge tb_clk);
      #1;
   endtask

   function automatic logic [31:0] mk_word(input int k, input int j);
      if (k == 2 && j == 2) return 32'h0000_0000;
      if (k == 2 && j == 3) return 32'h0000_0001;
      return {8'(k + 1), 8'(j + 1), 8'(k * 37 + j), 8'(8'hA0 + j)};
   endfunction

   function automatic logic [191:0] frame_bits(input int k);
      logic [191:0] f;
      for (int j = 0; j < 6; j++) f[j*32 +: 32] = mk_word(k, j);
      return f;
   endfunction

   task automatic send_word(input logic [31:0] w);
      ahb_buffer         = w;
      ahb_data_available = 1'b1;
      tick();
      ahb_data_available = 1'b0;
   endtask

   task automatic send_frame(input int k);
      send_word(START);
      for (int j = 0; j < 6; j++) send_word(mk_word(k, j));
      send_word(FEND);
      exp_q.push_back(frame_bits(k));
   endtask

   task automatic pop_check(input string tag);
      logic [191:0] e;
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 192'(prim_valid), 192'(1));
      chk({tag, "_vert"}, 192'(prim_vertices), 192'(e[143:0]));
      chk({tag, "_color"}, 192'(prim_color), 192'(e[167:144]));
      prim_read = 1'b1;
      tick();
      prim_read = 1'b0;
   endtask

   initial begin
      logic [31:0] basic [6];
      basic[0] = 32'h3322_1100; basic[1] = 32'h7766_5544; basic[2] = 32'hBBAA_9988;
      basic[3] = 32'hFFEE_DDCC; basic[4] = 32'h7654_3210; basic[5] = 32'hFEDB_CA98;

      n_rst = 1'b0; ahb_buffer = '0; ahb_data_available = 1'b0; prim_read = 1'b0;
      tick(); tick();
      chk("rst_valid", 192'(prim_valid), 192'(0));
      chk("rst_count", 192'(prim_count), 192'(0));
      chk("rst_ferr", 192'(frame_error), 192'(0));
      chk("rst_errcnt", 192'(err_count), 192'(0));
      chk("rst_vert", 192'(prim_vertices), 192'(0));
      chk("rst_color", 192'(prim_color), 192'(0));
      chk("rst_rdy", 192'(ahb_user_read_buffer), 192'(1));
      n_rst = 1'b1;

      // Basic frame with hand-decoded fields
      send_word(START);
      for (int j = 0; j < 6; j++) begin
         chk("basic_rdy", 192'(ahb_user_read_buffer), 192'(1));
         send_word(basic[j]);
      end
      send_word(FEND);
      chk("basic_valid", 192'(prim_valid), 192'(1));
      chk("basic_count", 192'(prim_count), 192'(1));
      chk("basic_vert", 192'(prim_vertices),
          192'(144'h3210_FFEE_DDCC_BBAA_9988_7766_5544_3322_1100));
      chk("basic_color", 192'(prim_color), 192'(24'h98_7654));
      tri_v = unpack_triangle(prim_vertices);
      chk("basic_qy", 192'(tri_v.q.y), 192'(16'h9988));
      prim_read = 1'b1; tick(); prim_read = 1'b0;
      chk("basic_popcnt", 192'(prim_count), 192'(0));
      chk("basic_popvld", 192'(prim_valid), 192'(0));

      // Pop while empty is ignored
      prim_read = 1'b1; tick(); prim_read = 1'b0;
      chk("uflow_count", 192'(prim_count), 192'(0));
      chk("uflow_valid", 192'(prim_valid), 192'(0));

      // Ten idle cycles in the middle of LOAD
      send_word(START);
      for (int j = 0; j < 3; j++) send_word(basic[j]);
      ahb_buffer = 32'h0000_0005;
      repeat (10) tick();
      chk("idle_count", 192'(prim_count), 192'(0));
      chk("idle_ferr", 192'(frame_error), 192'(0));
      for (int j = 3; j < 6; j++) send_word(basic[j]);
      send_word(FEND);
      chk("idle_count1", 192'(prim_count), 192'(1));
      chk("idle_vert", 192'(prim_vertices),
          192'(144'h3210_FFEE_DDCC_BBAA_9988_7766_5544_3322_1100));
      prim_read = 1'b1; tick(); prim_read = 1'b0;

      // Fill to DEPTH, stall the fifth frame, then release with one pop
      for (int k = 0; k < 4; k++) send_frame(k);
      chk("full_count", 192'(prim_count), 192'(4));
      chk("full_rdy", 192'(ahb_user_read_buffer), 192'(0));
      ahb_buffer = START; ahb_data_available = 1'b1;
      repeat (3) tick();
      chk("stall_count", 192'(prim_count), 192'(4));
      chk("stall_ferr", 192'(frame_error), 192'(0));
      prim_read = 1'b1;
      #1;
      chk("stall_rdy_comb", 192'(ahb_user_read_buffer), 192'(0));
      pop_check("full_head");
      chk("release_count", 192'(prim_count), 192'(3));
      chk("release_rdy", 192'(ahb_user_read_buffer), 192'(1));
      send_frame(4);
      chk("refill_count", 192'(prim_count), 192'(4));
      for (int k = 0; k < 4; k++) pop_check("drain");
      chk("drain_count", 192'(prim_count), 192'(0));

      // Framing errors
      send_word(32'h0000_0005);
      chk("err1_pulse", 192'(frame_error), 192'(1));
      chk("err1_cnt", 192'(err_count), 192'(1));
      tick();
      chk("err1_clear", 192'(frame_error), 192'(0));
      send_word(START);
      for (int j = 0; j < 6; j++) send_word(mk_word(7, j));
      send_word(32'h0000_0002);
      chk("err2_pulse", 192'(frame_error), 192'(1));
      chk("err2_cnt", 192'(err_count), 192'(2));
      chk("err2_count", 192'(prim_count), 192'(0));
      send_word(START);
      for (int j = 0; j < 6; j++) send_word(mk_word(8, j));
      send_word(START);
      chk("err3_pulse", 192'(frame_error), 192'(1));
      chk("err3_cnt", 192'(err_count), 192'(3));
      for (int j = 0; j < 6; j++) send_word(mk_word(9, j));
      send_word(FEND);
      exp_q.push_back(frame_bits(9));
      chk("resync_count", 192'(prim_count), 192'(1));
      pop_check("resync");

      // Push and pop on the same edge
      send_frame(5);
      send_frame(6);
      send_word(START);
      for (int j = 0; j < 6; j++) send_word(mk_word(10, j));
      chk("pp_head_vert", 192'(prim_vertices), 192'(exp_q[0][143:0]));
      void'(exp_q.pop_front());
      exp_q.push_back(frame_bits(10));
      prim_read = 1'b1;
      send_word(FEND);
      prim_read = 1'b0;
      chk("pp_count", 192'(prim_count), 192'(2));
      pop_check("pp_a");
      pop_check("pp_b");

      // Reset in the middle of a frame
      send_frame(11);
      send_word(START);
      for (int j = 0; j < 3; j++) send_word(mk_word(12, j));
      n_rst = 1'b0; ahb_buffer = FEND; ahb_data_available = 1'b1;
      tick();
      ahb_data_available = 1'b0;
      exp_q.delete();
      chk("mrst_valid", 192'(prim_valid), 192'(0));
      chk("mrst_count", 192'(prim_count), 192'(0));
      chk("mrst_vert", 192'(prim_vertices), 192'(0));
      chk("mrst_color", 192'(prim_color), 192'(0));
      chk("mrst_errcnt", 192'(err_count), 192'(0));
      n_rst = 1'b1;
      send_frame(13);
      chk("mrst_count1", 192'(prim_count), 192'(1));
      pop_check("mrst_clean");

      // err_count saturation
      repeat (260) send_word(32'h0000_0005);
      chk("sat_cnt", 192'(err_count), 192'(8'hFF));
      chk("sat_count", 192'(prim_count), 192'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/prim_assembler.md
Name: prim_assembler

Overview:
- Parametrised successor to the single-slot texel assembler.
- Consumes a framed stream of bus words from the AHB slave buffer and unpacks each frame into one primitive: NUM_VERT vertices of x/y/z coordinates plus an RGB colour.
- Completed primitives are queued in a DEPTH-entry FIFO, so the bus side keeps streaming while the rasteriser drains.
- Adds framing-error detection, resynchronisation and an error counter.

Parameters:
- WORD_W, 32, bus word width.
- COORD_W, 16, width of each x/y/z coordinate.
- NUM_VERT, 3, vertices per primitive.
- COLOR_W, 8, width of each colour channel.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- FRAME_START, 32'h0000_0000, frame-open marker.
- FRAME_END, 32'h0000_0001, frame-close marker.

Derived widths:
- VERT_BITS = NUM_VERT*3*COORD_W.
- PAY_BITS = VERT_BITS + 3*COLOR_W.
- PRIM_WORDS = ceil(PAY_BITS/WORD_W); defaults give 168 bits in 6 words.

Ports:
- clk, in, 1, system clock.
- n_rst, in, 1, reset, synchronous, active-low.
- ahb_buffer, in, WORD_W, current bus word.
- ahb_data_available, in, 1, ahb_buffer holds a valid word.
- ahb_user_read_buffer, out, 1, block accepts a word this cycle.
- prim_read, in, 1, consumer pops the FIFO head.
- prim_valid, out, 1, FIFO not empty.
- prim_vertices, out, VERT_BITS, head vertices; p.x in the LSBs, then p.y, p.z, q.x, …
- prim_color, out, 3*COLOR_W, head colour; r in the LSBs, then g, b.
- prim_count, out, $clog2(DEPTH+1), FIFO occupancy.
- frame_error, out, 1, one-cycle pulse on a framing error.
- err_count, out, 8, saturating count of framing errors.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (n_rst low at a clk edge) forces:
  - state IDLE, word index 0, FIFO emptied;
  - prim_valid=0, prim_count=0, frame_error=0, err_count=0;
  - prim_vertices and prim_color = 0.
- Reset mid-frame discards the partial frame. Reset overrides all other inputs.
- Word acceptance:
  - ahb_user_read_buffer = (prim_count != DEPTH), combinational.
  - A word is accepted when ahb_data_available && ahb_user_read_buffer at a clk edge.
  - Non-accepted cycles change no state.
- FSM transitions (each on an accepted word):
  - IDLE: FRAME_START -> LOAD, index=0. Any other word: discard, pulse frame_error, increment err_count.
  - LOAD: word stored into payload slice [index*WORD_W +: WORD_W]; index increments. After the PRIM_WORDS-th word -> TAIL. Marker values inside LOAD are ordinary data; there is no escaping.
  - TAIL, word == FRAME_END: push payload into FIFO, -> IDLE.
  - TAIL, word == FRAME_START: pulse frame_error, drop payload, -> LOAD with index=0 (resync).
  - TAIL, any other word: pulse frame_error, drop payload, -> IDLE.
- Payload packing:
  - Word k fills payload bits [k*WORD_W +: WORD_W].
  - Bits above PAY_BITS in the last word are ignored.
- Latency: FRAME_END accepted at edge N gives prim_valid=1 and head data valid after edge N (visible from cycle N+1) when the FIFO was empty.
- Pop:
  - prim_read && prim_valid at an edge advances the head.
  - prim_read with prim_valid=0 is ignored: no underflow, no state change.
- Simultaneous push and pop: prim_count is unchanged, and the head advances to the older next entry, or to the new entry if count was 1.
- Full:
  - Push is impossible because acceptance is gated by ahb_user_read_buffer.
  - A pop in a full cycle re-enables acceptance from the next cycle only; there is no combinational path from prim_read to ahb_user_read_buffer.
- err_count saturates at 8'hFF.
- prim_vertices and prim_color show the FIFO head; they are held stable while prim_valid=1 and no pop occurs.

Decomposition:
- Shared package gets:
  - FRAME_START / FRAME_END defaults;
  - a prim_words() constant function;
  - pack/unpack helpers mapping flat vertices/colour onto the existing Triangle3D / Color typedefs for the default parameters.
- Sub-module prim_fifo: synchronous FIFO with WIDTH=PAY_BITS and DEPTH; ports push, pop, din, dout, count, full, empty.
- The FSM and payload register stay in prim_assembler.

Test Plan:
- Basic frame:
  - Stimulus: reset, then 0x0, 0x33221100, 0x77665544, 0xBBAA9988, 0xFFEEDDCC, 0x76543210, 0xFEDBCA98, 0x1 on consecutive cycles.
  - Expected one cycle after the last word: prim_valid=1, prim_count=1.
  - Expected vertices: p=(1100,3322,5544), q=(7766,9988,BBAA), r=(DDCC,FFEE,3210).
  - Expected colour: r=54, g=76, b=98 (hex); ahb_user_read_buffer=1 throughout.
- Fill and backpressure:
  - Stimulus: 5 frames with no prim_read.
  - Expected after the 4th FRAME_END: prim_count=4 and ahb_user_read_buffer=0; the 5th frame stalls with its words unconsumed.
  - Then one prim_read: accepted frames resume the cycle after.
- Framing errors:
  - Stimulus 1: 0x5 in IDLE. Expected: frame_error pulse, err_count=1.
  - Stimulus 2: frame with 0x2 in place of FRAME_END. Expected: err_count=2, FIFO unchanged.
  - Stimulus 3: frame whose tail is FRAME_START followed by a valid frame. Expected: err_count=3, only the second frame queued.
- Simultaneous push/pop:
  - Stimulus: count=2, prim_read asserted in the same cycle FRAME_END is accepted.
  - Expected: count stays 2, FIFO order preserved.
- Reset mid-frame:
  - Stimulus: n_rst low after 3 payload words.
  - Expected: outputs 0 at the next edge; a following clean frame decodes correctly.
- Idle behaviour:
  - ahb_data_available=0 for 10 cycles mid-LOAD: no state change, and the frame completes correctly afterwards.
  - prim_read while empty: ignored, count stays 0.
